// File: rtl/popcount.sv
// Combinational population count of a vector; used per chunk by the select engine.
module popcount #(
  parameter int unsigned INPUT_WIDTH = 8
) (
  input  logic [INPUT_WIDTH-1:0]       data_i,
  output logic [$clog2(INPUT_WIDTH):0] count_o
);

  localparam int unsigned CNT_WIDTH = $clog2(INPUT_WIDTH) + 1;

  always_comb begin
    count_o = '0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      count_o = count_o + CNT_WIDTH'(data_i[i]);
    end
  end

endmodule

// File: rtl/nth_one_finder.sv
// Multi-cycle rank select: position of the (n+1)-th set bit from the LSB,
// scanning CHUNK_WIDTH bits per cycle behind valid/ready handshakes.
module nth_one_finder #(
  parameter int unsigned INPUT_WIDTH = 64,
  parameter int unsigned CHUNK_WIDTH = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [INPUT_WIDTH-1:0]           data_i,
  input  logic [$clog2(INPUT_WIDTH):0]     n_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic                             found_o,
  output logic [$clog2(INPUT_WIDTH)-1:0]   idx_o,
  output logic [INPUT_WIDTH-1:0]           onehot_o
);

  localparam int unsigned IDX_WIDTH  = $clog2(INPUT_WIDTH);
  localparam int unsigned CNT_WIDTH  = $clog2(INPUT_WIDTH) + 1;
  localparam int unsigned NUM_CHUNKS = (INPUT_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
  localparam int unsigned PAD_WIDTH  = NUM_CHUNKS * CHUNK_WIDTH;
  localparam int unsigned PTR_WIDTH  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int unsigned OFF_WIDTH  = $clog2(CHUNK_WIDTH);
  localparam int unsigned PC_WIDTH   = $clog2(CHUNK_WIDTH) + 1;
  localparam int unsigned LAST_PTR   = NUM_CHUNKS - 1;

  generate
    if ((CHUNK_WIDTH < 2) || ((CHUNK_WIDTH & (CHUNK_WIDTH - 1)) != 0)) begin : g_bad_chunk_pow2
      $error("nth_one_finder: CHUNK_WIDTH must be a power of two >= 2");
    end
    if (CHUNK_WIDTH > INPUT_WIDTH) begin : g_bad_chunk_size
      $error("nth_one_finder: CHUNK_WIDTH must not exceed INPUT_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                 r_state,  w_state_nxt;
  logic [PAD_WIDTH-1:0]   r_data,   w_data_nxt;
  logic [CNT_WIDTH-1:0]   r_rem,    w_rem_nxt;
  logic [PTR_WIDTH-1:0]   r_ptr,    w_ptr_nxt;
  logic                   r_found,  w_found_nxt;
  logic [IDX_WIDTH-1:0]   r_idx,    w_idx_nxt;
  logic [INPUT_WIDTH-1:0] r_onehot, w_onehot_nxt;

  logic [PAD_WIDTH-1:0]   w_shifted;
  logic [CHUNK_WIDTH-1:0] w_chunk;
  logic [PC_WIDTH-1:0]    w_pc;
  logic [CNT_WIDTH-1:0]   w_run_cnt;
  logic                   w_hit;
  logic [OFF_WIDTH-1:0]   w_offset;
  logic [IDX_WIDTH-1:0]   w_idx_hit;
  logic [INPUT_WIDTH-1:0] w_onehot_hit;

  // Chunk ptr starts at bit ptr*CHUNK_WIDTH; CHUNK_WIDTH is a power of two.
  assign w_shifted = r_data >> {r_ptr, {OFF_WIDTH{1'b0}}};
  assign w_chunk   = w_shifted[CHUNK_WIDTH-1:0];

  popcount #(
    .INPUT_WIDTH(CHUNK_WIDTH)
  ) u_popcount (
    .data_i (w_chunk),
    .count_o(w_pc)
  );

  // Position of the rem-th set bit inside the current chunk.
  always_comb begin
    w_run_cnt = '0;
    w_hit     = 1'b0;
    w_offset  = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      if (w_chunk[i]) begin
        if (!w_hit && (w_run_cnt == r_rem)) begin
          w_hit    = 1'b1;
          w_offset = OFF_WIDTH'(i);
        end
        w_run_cnt = w_run_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign w_idx_hit    = IDX_WIDTH'({r_ptr, w_offset});
  assign w_onehot_hit = INPUT_WIDTH'(1) << w_idx_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_data   <= '0;
      r_rem    <= '0;
      r_ptr    <= '0;
      r_found  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_data   <= w_data_nxt;
      r_rem    <= w_rem_nxt;
      r_ptr    <= w_ptr_nxt;
      r_found  <= w_found_nxt;
      r_idx    <= w_idx_nxt;
      r_onehot <= w_onehot_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_data_nxt   = r_data;
    w_rem_nxt    = r_rem;
    w_ptr_nxt    = r_ptr;
    w_found_nxt  = r_found;
    w_idx_nxt    = r_idx;
    w_onehot_nxt = r_onehot;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid_i) begin
          w_data_nxt  = PAD_WIDTH'(data_i);
          w_rem_nxt   = n_i;
          w_ptr_nxt   = '0;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (r_rem < CNT_WIDTH'(w_pc)) begin
          w_found_nxt  = 1'b1;
          w_idx_nxt    = w_idx_hit;
          w_onehot_nxt = w_onehot_hit;
          w_state_nxt  = S_DONE;
        end else if (r_ptr == PTR_WIDTH'(LAST_PTR)) begin
          w_found_nxt  = 1'b0;
          w_idx_nxt    = '0;
          w_onehot_nxt = '0;
          w_state_nxt  = S_DONE;
        end else begin
          // Safe: this branch is only taken when rem >= pc.
          w_rem_nxt = r_rem - CNT_WIDTH'(w_pc);
          w_ptr_nxt = r_ptr + PTR_WIDTH'(1);
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign in_ready_o  = (r_state == S_IDLE);
  assign out_valid_o = (r_state == S_DONE);
  assign found_o     = r_found;
  assign idx_o       = r_idx;
  assign onehot_o    = r_onehot;

endmodule

// File: tb/tb_nth_one_finder.sv
// Directed bench for nth_one_finder: 16/4 instance plus a padded 10/4 instance.
module tb_nth_one_finder;

  logic        clk;
  logic        rst_ni;
  logic        sel;
  logic        in_valid;
  logic [15:0] data;
  logic [4:0]  n;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_found;
  logic [3:0]  a_idx;
  logic [15:0] a_onehot;
  logic        b_in_ready, b_out_valid, b_found;
  logic [3:0]  b_idx;
  logic [9:0]  b_onehot;

  logic        obs_in_ready, obs_out_valid, obs_found;
  logic [3:0]  obs_idx;
  logic [15:0] obs_onehot;

  int n_checks;
  int n_fails;

  nth_one_finder #(.INPUT_WIDTH(16), .CHUNK_WIDTH(4)) u_dut_a (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .in_valid_i (in_valid && !sel),
    .in_ready_o (a_in_ready),
    .data_i     (data),
    .n_i        (n),
    .out_valid_o(a_out_valid),
    .out_ready_i(out_ready),
    .found_o    (a_found),
    .idx_o      (a_idx),
    .onehot_o   (a_onehot)
  );

  nth_one_finder #(.INPUT_WIDTH(10), .CHUNK_WIDTH(4)) u_dut_b (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .in_valid_i (in_valid && sel),
    .in_ready_o (b_in_ready),
    .data_i     (data[9:0]),
    .n_i        (n),
    .out_valid_o(b_out_valid),
    .out_ready_i(out_ready),
    .found_o    (b_found),
    .idx_o      (b_idx),
    .onehot_o   (b_onehot)
  );

  assign obs_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign obs_out_valid = sel ? b_out_valid : a_out_valid;
  assign obs_found     = sel ? b_found     : a_found;
  assign obs_idx       = sel ? b_idx       : a_idx;
  assign obs_onehot    = sel ? {6'b0, b_onehot} : a_onehot;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for out_valid after the acceptance edge; checks latency and result.
  task automatic wait_result(input string tag, input int exp_lat, input logic exp_found,
                             input logic [3:0] exp_idx, input logic [15:0] exp_oh);
    int edges;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!obs_out_valid && edges < 30);
    chk({tag, "_latency"}, 32'(edges), 32'(exp_lat));
    chk({tag, "_found"}, 32'(obs_found), 32'(exp_found));
    chk({tag, "_idx"}, 32'(obs_idx), 32'(exp_idx));
    chk({tag, "_onehot"}, 32'(obs_onehot), 32'(exp_oh));
  endtask

  task automatic handshake_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(obs_out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(obs_in_ready), 32'd1);
  endtask

  task automatic req(input string tag, input logic [15:0] d, input logic [4:0] rank,
                     input int exp_lat, input logic exp_found,
                     input logic [3:0] exp_idx, input logic [15:0] exp_oh);
    chk({tag, "_in_ready"}, 32'(obs_in_ready), 32'd1);
    data     = d;
    n        = rank;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(tag, exp_lat, exp_found, exp_idx, exp_oh);
    handshake_out(tag);
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst_ni    = 1'b0;
    sel       = 1'b0;
    in_valid  = 1'b0;
    data      = '0;
    n         = '0;
    out_ready = 1'b0;

    #12;
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_found", 32'(a_found), 32'd0);
    chk("rst_idx", 32'(a_idx), 32'd0);
    chk("rst_onehot", 32'(a_onehot), 32'd0);
    chk("rst_b_in_ready", 32'(b_in_ready), 32'd1);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    req("t1_lsb",      16'h0001, 5'd0,  1, 1'b1, 4'd0,  16'h0001);
    req("t2_n3",       16'h8421, 5'd3,  4, 1'b1, 4'd15, 16'h8000);
    req("t2_n1",       16'h8421, 5'd1,  2, 1'b1, 4'd5,  16'h0020);
    req("t3_ffff_n5",  16'hFFFF, 5'd5,  2, 1'b1, 4'd5,  16'h0020);
    req("t3_notfound", 16'h00F0, 5'd4,  4, 1'b0, 4'd0,  16'h0000);
    req("t3_zero",     16'h0000, 5'd0,  4, 1'b0, 4'd0,  16'h0000);
    req("t3_big_n",    16'h8421, 5'd31, 4, 1'b0, 4'd0,  16'h0000);
    req("t3_ffff_n15", 16'hFFFF, 5'd15, 4, 1'b1, 4'd15, 16'h8000);

    // Backpressure in DONE with a competing request held on the input.
    data     = 16'h0100;
    n        = 5'd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    data = 16'h0002;
    wait_result("t4_first", 3, 1'b1, 4'd8, 16'h0100);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", 32'(obs_out_valid), 32'd1);
      chk("t4_hold_in_ready", 32'(obs_in_ready), 32'd0);
      chk("t4_hold_idx", 32'(obs_idx), 32'd8);
      chk("t4_hold_onehot", 32'(obs_onehot), 32'h0100);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t4_idle_valid", 32'(obs_out_valid), 32'd0);
    chk("t4_idle_in_ready", 32'(obs_in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t4_accepted", 32'(obs_in_ready), 32'd0);
    wait_result("t4_second", 1, 1'b1, 4'd1, 16'h0002);
    handshake_out("t4_second");

    // Reset in the middle of a scan drops the transaction.
    data     = 16'h8000;
    n        = 5'd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_ni = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(obs_out_valid), 32'd0);
    chk("t5_rst_in_ready", 32'(obs_in_ready), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t5_no_result", 32'(obs_out_valid), 32'd0);
    end
    req("t5_after", 16'h0008, 5'd0, 1, 1'b1, 4'd3, 16'h0008);

    // Padded 10-bit instance.
    sel = 1'b1;
    #1;
    req("t6_pad_hit",  16'h0200, 5'd0, 3, 1'b1, 4'd9, 16'h0200);
    req("t6_pad_miss", 16'h0200, 5'd1, 3, 1'b0, 4'd0, 16'h0000);
    req("t6_pad_mid",  16'h0150, 5'd1, 2, 1'b1, 4'd6, 16'h0040);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
